// File: rtl/hazard_forward_ctrl_if.sv
// Control-path bundle between the pipeline registers and the hazard/forwarding unit.
// The pipeline side is the master; the hazard_forward_ctrl block is the slave.
interface hazard_forward_ctrl_if #(
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_SRC     = 2,
   parameter int STALL_CNT_W = 16
);
   logic                          id_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
   logic [NUM_SRC-1:0]            id_rs_used;
   logic                          ex_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0]         ex_rd;
   logic                          ex_reg_write;
   logic                          ex_mem_read;
   logic                          ex_is_md;
   logic [REG_ADDR_W-1:0]         exmem_rd;
   logic                          exmem_reg_write;
   logic                          exmem_mem_read;
   logic [REG_ADDR_W-1:0]         memwb_rd;
   logic                          memwb_reg_write;
   logic [2*NUM_SRC-1:0]          fwd_sel;
   logic                          stall_if_id;
   logic                          bubble_ex;
   logic                          hold_ex;
   logic                          md_done;
   logic [STALL_CNT_W-1:0]        stall_cycles;

   modport master (
      output id_valid, id_rs, id_rs_used, ex_valid, ex_rs, ex_rd, ex_reg_write,
             ex_mem_read, ex_is_md, exmem_rd, exmem_reg_write, exmem_mem_read,
             memwb_rd, memwb_reg_write,
      input  fwd_sel, stall_if_id, bubble_ex, hold_ex, md_done, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, ex_valid, ex_rs, ex_rd, ex_reg_write,
             ex_mem_read, ex_is_md, exmem_rd, exmem_reg_write, exmem_mem_read,
             memwb_rd, memwb_reg_write,
      output fwd_sel, stall_if_id, bubble_ex, hold_ex, md_done, stall_cycles
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding, load-use hazard detection and multi-cycle (mul/div) EX occupancy control,
// with a saturating count of front-end stall cycles.
module hazard_forward_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_SRC     = 2,
   parameter int MD_LAT      = 4,
   parameter int STALL_CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   hazard_forward_ctrl_if.slave bus
);
   localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_md_done;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic [2*NUM_SRC-1:0]   w_fwd_sel;
   logic                   w_lu_match;
   logic                   w_load_use;
   logic                   w_md_start;
   logic                   w_hold;
   logic                   w_bubble;
   logic                   w_stall;

   // A load still in EX/MEM has no data yet, so it may only be forwarded later from MEM/WB.
   always_comb begin
      w_fwd_sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (bus.exmem_reg_write && !bus.exmem_mem_read &&
             bus.exmem_rd == bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W] &&
             bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0)
            w_fwd_sel[2*i +: 2] = 2'b01;
         else if (bus.memwb_reg_write &&
                  bus.memwb_rd == bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W] &&
                  bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0)
            w_fwd_sel[2*i +: 2] = 2'b10;
      end
   end

   always_comb begin
      w_lu_match = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (bus.id_rs_used[i] && bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W] == bus.ex_rd)
            w_lu_match = 1'b1;
      end
   end

   assign w_load_use = (r_state == S_IDLE) && bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
                       bus.ex_reg_write && (bus.ex_rd != '0) && w_lu_match;
   assign w_md_start = (r_state == S_IDLE) && bus.ex_valid && bus.ex_is_md;
   assign w_hold     = w_md_start || (r_state == S_BUSY);
   // A multi-cycle start takes precedence: EX is held, so no bubble is injected.
   assign w_bubble   = w_load_use && !w_md_start;
   assign w_stall    = w_hold || w_bubble;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_md_done   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_md_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_md_start) begin
                  r_state <= S_BUSY;
                  r_cnt   <= CNT_LOAD;
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) begin
                  r_state   <= S_DONE;
                  r_md_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign bus.fwd_sel      = w_fwd_sel;
   assign bus.stall_if_id  = w_stall;
   assign bus.bubble_ex    = w_bubble;
   assign bus.hold_ex      = w_hold;
   assign bus.md_done      = r_md_done;
   assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Parametrised successor to the pipeline forwarding unit. It generates forwarding selects for NUM_SRC source operands in EX, and detects load-use hazards for the instruction in ID. It also tracks a multi-cycle (mul/div) unit occupying EX for MD_LAT cycles, freezing the front end while that unit is busy. It sits in the control path between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF-ID enables, and includes a saturating stall-cycle counter for performance reporting.

Parameters:
REG_ADDR_W, 5, register index width; index 0 is hard-wired zero.
NUM_SRC, 2, number of source operands per instruction (1..4).
MD_LAT, 4, multi-cycle unit latency in cycles (>=2).
STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock, all state rising-edge.
rst  in  1  reset, asynchronous, active-high.
id_valid  in  1  valid instruction in ID.
id_rs  in  NUM_SRC*REG_ADDR_W  ID sources; source i at [i*REG_ADDR_W +: REG_ADDR_W].
id_rs_used  in  NUM_SRC  bit i: source i is actually read.
ex_valid  in  1  valid instruction in EX.
ex_rs  in  NUM_SRC*REG_ADDR_W  EX sources, same packing.
ex_rd  in  REG_ADDR_W  EX destination.
ex_reg_write  in  1  EX writes rd.
ex_mem_read  in  1  EX instruction is a load.
ex_is_md  in  1  EX instruction is a multi-cycle op.
exmem_rd  in  REG_ADDR_W  EX/MEM destination.
exmem_reg_write  in  1  EX/MEM writes rd.
exmem_mem_read  in  1  EX/MEM instruction is a load (data not yet available).
memwb_rd  in  REG_ADDR_W  MEM/WB destination.
memwb_reg_write  in  1  MEM/WB writes rd.
fwd_sel  out  2*NUM_SRC  per source: 00 regfile, 01 EX/MEM, 10 MEM/WB; 11 never driven.
stall_if_id  out  1  hold PC and IF/ID.
bubble_ex  out  1  insert bubble into ID/EX.
hold_ex  out  1  hold ID/EX and EX (multi-cycle op in progress).
md_done  out  1  one-cycle pulse: multi-cycle result valid this cycle.
stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall_if_id=1.

Behaviour:
- Forwarding is combinational, zero latency, evaluated independently per source i with s = ex_rs[i]:
  - 01 if exmem_reg_write && !exmem_mem_read && exmem_rd==s && s!=0;
  - else 10 if memwb_reg_write && memwb_rd==s && s!=0;
  - else 00.
  - Priority: EX/MEM over MEM/WB. A load in EX/MEM is never forwarded from EX/MEM.
- Load-use hazard (combinational, evaluated only in state IDLE):
  - Condition: id_valid && ex_valid && ex_mem_read && ex_reg_write && ex_rd!=0, and for some i, id_rs_used[i] && id_rs[i]==ex_rd.
  - Result: stall_if_id=1 and bubble_ex=1 in the same cycle. The hazard lasts exactly 1 cycle because the load advances.
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when ex_valid && ex_is_md. The counter loads MD_LAT-2.
  - BUSY: counter decrements each cycle; when counter==0, go to DONE.
  - DONE: md_done=1 for one cycle, then IDLE.
  - Total occupancy: start cycle + (MD_LAT-2)+1 BUSY cycles + DONE. EX is frozen for MD_LAT cycles, from the start cycle through the last BUSY cycle.
  - hold_ex=1 and stall_if_id=1 in the start cycle (IDLE with md start) and in every BUSY cycle.
  - In DONE, hold_ex=0 and the op leaves EX normally. The forwarding logic covers it in later stages.
  - bubble_ex=0 whenever hold_ex=1; load-use logic is suppressed outside IDLE.
- Simultaneous events: a multi-cycle start overrides load-use; the two cannot both be true for the same EX instruction, but the md path wins by definition. ex_is_md asserted while in BUSY or DONE is ignored.
- stall_cycles increments on every cycle where stall_if_id=1 and saturates at all-ones (no wrap).
- Reset, including mid-operation: FSM -> IDLE, counter=0, stall_cycles=0, md_done=0. Combinational outputs follow inputs immediately after reset with IDLE state (hold_ex=0 unless a new start is present).
- Widths: fwd_sel field i occupies [2*i +: 2].

Test Plan:
1. ex_rs0=5, exmem_rd=5, exmem_reg_write=1, memwb_rd=5, memwb_reg_write=1 -> fwd_sel[1:0]=01. Clearing exmem_reg_write -> 10. ex_rs0=0 with both matching -> 00.
2. exmem_mem_read=1, exmem_rd=7, memwb_rd=7 writing, ex_rs1=7 -> fwd_sel[3:2]=10. With memwb_reg_write=0 -> 00.
3. Load in EX with ex_rd=3; ID has id_rs1=3, id_rs_used=2'b10 -> stall_if_id=1, bubble_ex=1 for 1 cycle, stall_cycles 0->1. Same stimulus with id_rs_used=2'b01 -> no stall.
4. MD_LAT=4, ex_is_md pulse at cycle 0 -> hold_ex/stall_if_id high in cycles 0-3, md_done high in cycle 4 only, stall_cycles=4. A concurrent load-use condition yields no bubble_ex.
5. rst asserted asynchronously in cycle 2 of a BUSY sequence -> hold_ex, md_done and stall_cycles drop to 0 immediately. After release with no start, the FSM stays IDLE.
6. STALL_CNT_W=3, 10 consecutive stall cycles -> stall_cycles reaches 7 and holds at 7.
